// File: rtl/exp2_pkg.sv
// Shared types and constants for the iterative 2^x unit.
package exp2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } exp2_state_t;

  localparam logic [15:0] MANT_ONE = 16'h8000;

  // round(2^(2^-(k+1)) * 2^15), one per fraction bit, MSB first
  localparam logic [15:0] EXP2_C [5] = '{16'hB505, 16'h9838, 16'h8B96, 16'h85AB, 16'h82CE};

  function automatic logic [15:0] exp2_coef(input logic [2:0] k);
    case (k)
      3'd0:    return EXP2_C[0];
      3'd1:    return EXP2_C[1];
      3'd2:    return EXP2_C[2];
      3'd3:    return EXP2_C[3];
      3'd4:    return EXP2_C[4];
      default: return MANT_ONE;
    endcase
  endfunction

endpackage

// File: rtl/exp2_mul_q15.sv
// Combinational Q1.15 multiply: y = (a * b) >> (W-1), truncated to W bits.
module exp2_mul_q15 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [2*W-1:0] prod;

  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign y    = W'(prod >> (W - 1));

endmodule

// File: rtl/exp2.sv
// Iterative antilog: U3.5 exponent in, 2^x as 8-bit integer out, one fraction bit per clock.
// Build option EXP2_ROUND_EN selects round-half-up in NORM instead of truncation.
module exp2
  import exp2_pkg::*;
#(
  parameter int FRAC_W = 5,
  parameter int MANT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h,
  input  logic [7:0] in,
  output logic       flag,
  output logic [7:0] out
);

  localparam int FB = MANT_W - 1;
  localparam int PW = MANT_W + 8;

  exp2_state_t       state;
  logic [7:0]        x_q;
  logic [MANT_W-1:0] m_q;
  logic [MANT_W-1:0] m_mul;
  logic [2:0]        k_q;
  logic              frac_bit;
  logic [PW-1:0]     p;
  logic [9:0]        ip;
  logic [7:0]        out_nxt;

  exp2_mul_q15 #(.W(MANT_W)) u_mul (
    .a(m_q),
    .b(exp2_coef(k_q)),
    .y(m_mul)
  );

  assign frac_bit = x_q[3'(FRAC_W - 1) - k_q];

  // Integer part of the exponent is a plain left shift of the mantissa.
  always_comb begin
    p  = PW'(m_q) << x_q[7:5];
    ip = 10'(p >> FB);
`ifdef EXP2_ROUND_EN
    ip = ip + 10'(p[FB-1]);
`endif
    out_nxt = (|ip[9:8]) ? 8'hFF : ip[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      flag  <= 1'b0;
      out   <= 8'h00;
      m_q   <= MANT_ONE;
      k_q   <= 3'd0;
      x_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          flag <= 1'b0;
          if (h) begin
            x_q   <= in;
            m_q   <= MANT_ONE;
            k_q   <= 3'd0;
            state <= MUL;
          end
        end
        MUL: begin
          if (frac_bit) m_q <= m_mul;
          k_q <= k_q + 3'd1;
          if (k_q == 3'(FRAC_W - 1)) state <= NORM;
        end
        NORM: begin
          out   <= out_nxt;
          flag  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          flag  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp2.sv
// Randomized self-checking bench for exp2 against an arithmetic 2^x reference.
module tb_exp2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       h = 1'b0;
  logic [7:0] in = 8'h00;
  logic       flag;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp2 dut (
    .clk(clk),
    .reset(reset),
    .h(h),
    .in(in),
    .flag(flag),
    .out(out)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mantissa after applying each set fraction bit's factor, truncated each step.
  function automatic longint ref_m(input logic [7:0] x);
    longint m = 32768;
    longint c [5] = '{46341, 38968, 35734, 34219, 33486};
    for (int i = 0; i < 5; i++)
      if (x[4-i]) m = (m * c[i]) >> 15;
    return m;
  endfunction

  function automatic longint ref_out(input logic [7:0] x);
    longint p = ref_m(x) << x[7:5];
    longint r = p >> 15;
`ifdef EXP2_ROUND_EN
    r = r + ((p >> 14) & 1);
`endif
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic run_one(input logic [7:0] v, input string tag);
    int lat;
    @(negedge clk);
    h = 1'b1;
    in = v;
    @(posedge clk);
    #1;
    h = 1'b0;
    in = 8'($urandom);
    lat = 0;
    while (!flag && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_out"}, out, ref_out(v));
    @(posedge clk);
    #1;
    chk({tag, "_flag_fall"}, flag, 0);
  endtask

  initial begin
    logic [7:0] vals [4];
    int lat;
    int last;
    int pulses;
    real t;
    real d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_flag", flag, 0);
    chk("rst_m", dut.m_q, 32768);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_out", out, 0);
    chk("idle_flag", flag, 0);

    run_one(8'h00, "zero");
    chk("zero_is_one", out, 1);
    run_one(8'h20, "two");
    chk("two_val", out, 2);
    run_one(8'hE0, "p7");
    chk("p7_val", out, 128);
    run_one(8'h10, "half");
    chk("half_m", dut.m_q, 46341);
    chk("half_val", out, 1);
    run_one(8'hFF, "full");
    chk("full_m", dut.m_q, 64133);
`ifdef EXP2_ROUND_EN
    chk("full_val", out, 251);
`else
    chk("full_val", out, 250);
`endif

    // Reset while the multiply loop is at step 3.
    @(negedge clk);
    h = 1'b1;
    in = 8'hFF;
    @(posedge clk);
    #1;
    h = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_k", dut.k_q, 3);
    reset = 1'b0;
    #1;
    chk("mid_out", out, 0);
    chk("mid_flag", flag, 0);
    chk("mid_k_clr", dut.k_q, 0);
    chk("mid_m_clr", dut.m_q, 32768);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (flag) pulses++;
    end
    chk("mid_noflag", pulses, 0);
    chk("mid_out_hold", out, 0);
    run_one(8'h40, "after_rst");
    chk("after_rst_val", out, 4);

    // h held high: back-to-back restarts, in scrambled after each start edge.
    for (int j = 0; j < 4; j++) vals[j] = 8'($urandom);
    last = 0;
    @(negedge clk);
    h = 1'b1;
    in = vals[0];
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      in = 8'($urandom);
      lat = 0;
      while (!flag && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("hold_lat", lat, 6);
      chk("hold_out", out, ref_out(vals[j]));
      if (j > 0) chk("hold_spacing", cyc - last, 8);
      last = cyc;
      @(posedge clk);
      #1;
      chk("hold_flag_fall", flag, 0);
      @(negedge clk);
      in = vals[(j + 1) % 4];
      if (j == 3) h = 1'b0;
    end

    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      run_one(v, "rnd");
      t = 2.0 ** (real'(v) / 32.0);
      d = real'(out) - t;
      if (d < 0.0) d = -d;
      chk("rnd_tol", (d <= 1.1) ? 1 : 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
